// File: rtl/async_receiver_par_pkg.sv
// Shared definitions for the odd-parity UART receiver: FSM encoding, tick-count
// sample points and the baud increment formula shared with the transmitter.
package async_receiver_par_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4,
    StBreak  = 3'd5
  } rxState_e;

  localparam int unsigned DataWidth    = 8;
  localparam int unsigned TickCntWidth = 4;
  localparam int unsigned BitIdxWidth  = 3;

  localparam logic [TickCntWidth-1:0] SampFirst = 4'd7;
  localparam logic [TickCntWidth-1:0] SampMid   = 4'd8;
  localparam logic [TickCntWidth-1:0] SampLast  = 4'd9;
  localparam logic [TickCntWidth-1:0] TickLast  = 4'd15;
  localparam logic [BitIdxWidth-1:0]  BitLast   = 3'd7;

  // Phase increment; rounding term keeps TX and RX rates identical.
  function automatic longint unsigned baudInc(
    input longint unsigned clkFrequency,
    input longint unsigned baud,
    input longint unsigned oversampling,
    input longint unsigned accWidth
  );
    return (((baud * oversampling) << (accWidth - 64'd7)) + (clkFrequency >> 8))
           / (clkFrequency >> 7);
  endfunction

endpackage

// File: rtl/async_receiver_par_baud_tick_gen.sv
// Fractional phase-accumulator tick generator; tick pulses one clk per
// oversampling period.
module baud_tick_gen
  import async_receiver_par_pkg::*;
#(
  parameter int unsigned ClkFrequency = 50000000,
  parameter int unsigned Baud         = 19200,
  parameter int unsigned Oversampling = 16,
  parameter int unsigned AccWidth     = 16
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam longint unsigned IncFull = baudInc(64'(ClkFrequency), 64'(Baud),
                                                64'(Oversampling), 64'(AccWidth));
  localparam logic [AccWidth:0] Inc = IncFull[AccWidth:0];

  logic [AccWidth:0] acc;

  // Carry out of the low bits is the tick; it is dropped on the next add.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else begin
      acc <= {1'b0, acc[AccWidth-1:0]} + Inc;
    end
  end

  assign tick = acc[AccWidth];

endmodule

// File: rtl/async_receiver_par.sv
// RS-232 receiver: 8 data bits LSB-first, odd parity, 1 stop, 16x oversampling
// with a 3-sample majority vote per bit.
module async_receiver_par
  import async_receiver_par_pkg::*;
#(
  parameter int unsigned ClkFrequency = 50000000,
  parameter int unsigned Baud         = 19200,
  parameter int unsigned Oversampling = 16,
  parameter int unsigned AccWidth     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RxD,
  output logic [DataWidth-1:0] RxD_data,
  output logic                 RxD_data_ready,
  output logic                 RxD_parity_error,
  output logic                 RxD_frame_error,
  output logic                 RxD_idle
);

  logic tick;

  baud_tick_gen #(
    .ClkFrequency (ClkFrequency),
    .Baud         (Baud),
    .Oversampling (Oversampling),
    .AccWidth     (AccWidth)
  ) uTickGen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Two-flop synchroniser, reset to the idle level so reset never looks like a start bit.
  logic [1:0] rxSync;
  logic       rxs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxSync <= 2'b11;
    end else begin
      rxSync <= {rxSync[0], RxD};
    end
  end

  assign rxs = rxSync[1];

  rxState_e                 state;
  logic [TickCntWidth-1:0]  tcnt;
  logic [BitIdxWidth-1:0]   bitIdx;
  logic [DataWidth-1:0]     shreg;
  logic                     par;
  logic                     sampA;
  logic                     sampB;
  logic                     vote;

  // Majority of the samples at tcnt 7, 8 and the live one at tcnt 9.
  assign vote = (sampA & sampB) | (sampA & rxs) | (sampB & rxs);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= StIdle;
      tcnt             <= '0;
      bitIdx           <= '0;
      shreg            <= '0;
      par              <= 1'b0;
      sampA            <= 1'b1;
      sampB            <= 1'b1;
      RxD_data         <= '0;
      RxD_data_ready   <= 1'b0;
      RxD_parity_error <= 1'b0;
      RxD_frame_error  <= 1'b0;
      RxD_idle         <= 1'b1;
    end else begin
      RxD_data_ready <= 1'b0;
      if (tick) begin
        tcnt <= tcnt + 4'd1;
        if (tcnt == SampFirst) sampA <= rxs;
        if (tcnt == SampMid)   sampB <= rxs;

        unique case (state)
          StIdle: begin
            if (!rxs) begin
              state    <= StStart;
              tcnt     <= '0;
              RxD_idle <= 1'b0;
            end
          end

          StStart: begin
            if (tcnt == SampLast && vote) begin
              state    <= StIdle;
              tcnt     <= '0;
              RxD_idle <= 1'b1;
            end else if (tcnt == TickLast) begin
              state  <= StData;
              bitIdx <= '0;
            end
          end

          StData: begin
            if (tcnt == SampLast) shreg <= {vote, shreg[DataWidth-1:1]};
            if (tcnt == TickLast) begin
              if (bitIdx == BitLast) begin
                state <= StParity;
              end else begin
                bitIdx <= bitIdx + 3'd1;
              end
            end
          end

          StParity: begin
            if (tcnt == SampLast) par <= vote;
            if (tcnt == TickLast) state <= StStop;
          end

          // Frame completes at mid-stop so a start bit straight after can be caught.
          StStop: begin
            if (tcnt == SampLast) begin
              RxD_data         <= shreg;
              RxD_parity_error <= ~(^{shreg, par});
              RxD_frame_error  <= ~vote;
              RxD_data_ready   <= 1'b1;
              tcnt             <= '0;
              if (vote) begin
                state    <= StIdle;
                RxD_idle <= 1'b1;
              end else begin
                state <= StBreak;
              end
            end
          end

          StBreak: begin
            if (rxs) begin
              state    <= StIdle;
              tcnt     <= '0;
              RxD_idle <= 1'b1;
            end
          end

          default: begin
            state    <= StIdle;
            RxD_idle <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_async_receiver_par.sv
// Self-checking bench for async_receiver_par: bit-banged frames checked against a
// frame-level reference model.
module tb_async_receiver_par;

  localparam int unsigned ClkFreq  = 1600000;
  localparam int unsigned BaudRate = 10000;
  localparam int unsigned BitClk   = 160;
  localparam int unsigned FastClk  = 155;

  logic       clk = 1'b0;
  logic       rst;
  logic       RxD;
  logic [7:0] RxD_data;
  logic       RxD_data_ready;
  logic       RxD_parity_error;
  logic       RxD_frame_error;
  logic       RxD_idle;

  always #5 clk = ~clk;

  async_receiver_par #(
    .ClkFrequency (ClkFreq),
    .Baud         (BaudRate),
    .Oversampling (16),
    .AccWidth     (16)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .RxD              (RxD),
    .RxD_data         (RxD_data),
    .RxD_data_ready   (RxD_data_ready),
    .RxD_parity_error (RxD_parity_error),
    .RxD_frame_error  (RxD_frame_error),
    .RxD_idle         (RxD_idle)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       parErr;
    logic       frmErr;
  } rxRec_t;

  rxRec_t got[$];
  rxRec_t monRec;
  int     passCnt  = 0;
  int     checkCnt = 0;

  // Every clk that data_ready is high logs one record, so a stretched pulse shows as extra frames.
  always @(negedge clk) begin
    if (RxD_data_ready === 1'b1) begin
      monRec.data   = RxD_data;
      monRec.parErr = RxD_parity_error;
      monRec.frmErr = RxD_frame_error;
      got.push_back(monRec);
    end
  end

  // Reference: odd parity means the total count of ones over data+parity must be odd.
  function automatic rxRec_t modelFrame(input logic [7:0] d, input logic p, input logic s);
    rxRec_t r;
    int     ones;
    ones     = $countones(d) + (p ? 1 : 0);
    r.data   = d;
    r.parErr = ((ones % 2) == 0);
    r.frmErr = !s;
    return r;
  endfunction

  function automatic logic oddParBit(input logic [7:0] d);
    return (($countones(d) % 2) == 0);
  endfunction

  function automatic rxRec_t gotAt(input int idx);
    rxRec_t r;
    r = 'x;
    if (idx < got.size()) r = got[idx];
    return r;
  endfunction

  task automatic sendBits(input logic [7:0] d, input logic p, input logic s,
                          input int unsigned bitClk, input int nBits, input int unsigned tailClk);
    logic [10:0] bits;
    bits = {s, p, d, 1'b0};
    for (int i = 0; i < nBits; i++) begin
      RxD = bits[i];
      repeat (bitClk) @(negedge clk);
    end
    if (nBits < 11) begin
      RxD = bits[nBits];
      repeat (tailClk) @(negedge clk);
    end
  endtask

  task automatic sendFrame(input logic [7:0] d, input logic p, input logic s, input int unsigned bitClk);
    sendBits(d, p, s, bitClk, 11, 0);
  endtask

  task automatic idleLine(input int unsigned nClk);
    RxD = 1'b1;
    repeat (nClk) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    RxD = 1'b1;
    repeat (4) @(negedge clk);
    checkCnt++;
    if ({RxD_data, RxD_data_ready, RxD_parity_error, RxD_frame_error} !== 11'h000)
      $display("FAIL reset_outputs: got %h expected 000",
               {RxD_data, RxD_data_ready, RxD_parity_error, RxD_frame_error});
    else passCnt++;
    checkCnt++;
    if (RxD_idle !== 1'b1) $display("FAIL reset_idle: got %b expected 1", RxD_idle);
    else passCnt++;
    rst = 1'b0;
    got.delete();
    idleLine(2 * BitClk);
    checkCnt++;
    if (got.size() != 0) $display("FAIL reset_no_pulse: got %0d pulses expected 0", got.size());
    else passCnt++;
  endtask

  task automatic test_basic();
    rxRec_t exp;
    got.delete();
    sendFrame(8'h55, 1'b1, 1'b1, BitClk);
    idleLine(2 * BitClk);
    exp = modelFrame(8'h55, 1'b1, 1'b1);
    checkCnt++;
    if (got.size() != 1) $display("FAIL basic_count: got %0d pulses expected 1", got.size());
    else passCnt++;
    checkCnt++;
    if (gotAt(0) !== exp) $display("FAIL basic_frame: got %h expected %h", gotAt(0), exp);
    else passCnt++;
    checkCnt++;
    if (RxD_idle !== 1'b1) $display("FAIL basic_idle: got %b expected 1", RxD_idle);
    else passCnt++;
  endtask

  task automatic test_parity_error();
    rxRec_t exp;
    got.delete();
    sendFrame(8'h07, 1'b1, 1'b1, BitClk);
    idleLine(2 * BitClk);
    exp = modelFrame(8'h07, 1'b1, 1'b1);
    checkCnt++;
    if (got.size() != 1) $display("FAIL parity_count: got %0d pulses expected 1", got.size());
    else passCnt++;
    checkCnt++;
    if (gotAt(0) !== exp) $display("FAIL parity_frame: got %h expected %h", gotAt(0), exp);
    else passCnt++;
    checkCnt++;
    if (RxD_parity_error !== 1'b1) $display("FAIL parity_flag_held: got %b expected 1", RxD_parity_error);
    else passCnt++;
  endtask

  task automatic test_break();
    rxRec_t exp;
    got.delete();
    sendFrame(8'hA3, oddParBit(8'hA3), 1'b0, BitClk);
    RxD = 1'b0;
    repeat (3 * BitClk) @(negedge clk);
    exp = modelFrame(8'hA3, oddParBit(8'hA3), 1'b0);
    checkCnt++;
    if (got.size() != 1) $display("FAIL break_count_low: got %0d pulses expected 1", got.size());
    else passCnt++;
    checkCnt++;
    if (gotAt(0) !== exp) $display("FAIL break_frame: got %h expected %h", gotAt(0), exp);
    else passCnt++;
    idleLine(2 * BitClk);
    checkCnt++;
    if (got.size() != 1 || RxD_idle !== 1'b1)
      $display("FAIL break_release: got %0d pulses idle %b expected 1 pulses idle 1", got.size(), RxD_idle);
    else passCnt++;
    sendFrame(8'h3C, oddParBit(8'h3C), 1'b1, BitClk);
    idleLine(BitClk);
    exp = modelFrame(8'h3C, oddParBit(8'h3C), 1'b1);
    checkCnt++;
    if (gotAt(1) !== exp || got.size() != 2)
      $display("FAIL break_next_frame: got %h (%0d pulses) expected %h (2 pulses)", gotAt(1), got.size(), exp);
    else passCnt++;
  endtask

  task automatic test_glitch();
    got.delete();
    RxD = 1'b0;
    repeat (40) @(negedge clk);
    checkCnt++;
    if (RxD_idle !== 1'b0) $display("FAIL glitch_start_seen: got idle %b expected 0", RxD_idle);
    else passCnt++;
    repeat (24) @(negedge clk);
    idleLine(3 * BitClk);
    checkCnt++;
    if (got.size() != 0) $display("FAIL glitch_no_pulse: got %0d pulses expected 0", got.size());
    else passCnt++;
    checkCnt++;
    if (RxD_idle !== 1'b1) $display("FAIL glitch_idle: got %b expected 1", RxD_idle);
    else passCnt++;
  endtask

  task automatic test_back_to_back();
    rxRec_t exp0;
    rxRec_t exp1;
    got.delete();
    sendFrame(8'h00, oddParBit(8'h00), 1'b1, FastClk);
    sendFrame(8'hFF, oddParBit(8'hFF), 1'b1, FastClk);
    idleLine(2 * BitClk);
    exp0 = modelFrame(8'h00, oddParBit(8'h00), 1'b1);
    exp1 = modelFrame(8'hFF, oddParBit(8'hFF), 1'b1);
    checkCnt++;
    if (got.size() != 2) $display("FAIL b2b_count: got %0d pulses expected 2", got.size());
    else passCnt++;
    checkCnt++;
    if (gotAt(0) !== exp0) $display("FAIL b2b_first: got %h expected %h", gotAt(0), exp0);
    else passCnt++;
    checkCnt++;
    if (gotAt(1) !== exp1) $display("FAIL b2b_second: got %h expected %h", gotAt(1), exp1);
    else passCnt++;
  endtask

  task automatic test_reset_mid_frame();
    rxRec_t exp;
    got.delete();
    // Start bit plus data bits 0..3, then half of data bit 4.
    sendBits(8'h81, oddParBit(8'h81), 1'b1, BitClk, 5, BitClk / 2);
    checkCnt++;
    if (RxD_data !== 8'hFF) $display("FAIL midreset_held_data: got %h expected ff", RxD_data);
    else passCnt++;
    rst = 1'b1;
    #1;
    checkCnt++;
    if ({RxD_data, RxD_data_ready, RxD_parity_error, RxD_frame_error, RxD_idle} !== 12'h001)
      $display("FAIL midreset_outputs: got %h expected 001",
               {RxD_data, RxD_data_ready, RxD_parity_error, RxD_frame_error, RxD_idle});
    else passCnt++;
    RxD = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    idleLine(8 * BitClk);
    checkCnt++;
    if (got.size() != 0) $display("FAIL midreset_no_pulse: got %0d pulses expected 0", got.size());
    else passCnt++;
    sendFrame(8'h3C, oddParBit(8'h3C), 1'b1, BitClk);
    idleLine(BitClk);
    exp = modelFrame(8'h3C, oddParBit(8'h3C), 1'b1);
    checkCnt++;
    if (gotAt(0) !== exp || got.size() != 1)
      $display("FAIL midreset_next_frame: got %h (%0d pulses) expected %h (1 pulse)", gotAt(0), got.size(), exp);
    else passCnt++;
  endtask

  task automatic test_random();
    rxRec_t      expQ[$];
    logic [7:0]  d;
    logic        p;
    int unsigned bc;
    got.delete();
    for (int i = 0; i < 10; i++) begin
      d  = 8'($urandom_range(0, 255));
      p  = 1'($urandom_range(0, 1));
      bc = $urandom_range(156, 164);
      sendFrame(d, p, 1'b1, bc);
      expQ.push_back(modelFrame(d, p, 1'b1));
      if ($urandom_range(0, 1) == 1) idleLine(bc);
    end
    idleLine(2 * BitClk);
    checkCnt++;
    if (got.size() != expQ.size())
      $display("FAIL random_count: got %0d pulses expected %0d", got.size(), expQ.size());
    else passCnt++;
    for (int i = 0; i < expQ.size(); i++) begin
      checkCnt++;
      if (gotAt(i) !== expQ[i]) $display("FAIL random_frame_%0d: got %h expected %h", i, gotAt(i), expQ[i]);
      else passCnt++;
    end
  endtask

  initial begin
    #20ms;
    $display("FAIL timeout: simulation ran past its time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_parity_error();
    test_break();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
